serdesphy_rx_framer: RTL and testbench

- Receive-side framer and deserializer, the counterpart of the TX serializer/framer.
- Sits between the CDR/sampler output (one recovered bit per strobe) and the parallel receive interface (rx_data[3:0] / rx_valid).
- Hunts for the sync word that the TX inserts before every frame, then confirms frame alignment over several frames.
- Once aligned, emits 4-bit data nibbles, flags lock, and tracks lost syncs.

---
 rtl/serdesphy_rx_framer.sv | 195 +++++++++++++++++++
 tb/tb_serdesphy_rx_framer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/serdesphy_rx_framer.sv
// Receive framer: hunts for the sync word, confirms alignment over several frames,
// then deserializes data nibbles. Optional descrambler: SERDESPHY_RX_DESCRAMBLE_EN.
module serdesphy_rx_framer #(
    parameter logic [7:0] SYNC_WORD     = 8'hD2,
    parameter int         FRAME_NIBBLES = 8,
    parameter int         LOCK_CNT      = 3,
    parameter int         LOSS_CNT      = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_bit,
    input  logic       rx_bit_en,
    input  logic       resync,
    output logic [3:0] rx_data,
    output logic       rx_valid,
    output logic       frame_start,
    output logic       sync_lock,
    output logic [7:0] sync_miss_cnt
);

    localparam int DATA_BITS = FRAME_NIBBLES * 4;
    localparam int SLOT_LAST = DATA_BITS + 7;
    localparam int SLOT_W    = $clog2(SLOT_LAST + 1);

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_CHECK  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        sr_q, sr_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [3:0]        hits_q, hits_d;
    logic [3:0]        misses_q, misses_d;
    logic [3:0]        rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              frame_start_q, frame_start_d;
    logic              sync_lock_q, sync_lock_d;
    logic [7:0]        miss_cnt_q, miss_cnt_d;

    logic bit_in;
    logic in_data;
    logic is_last;
    logic nibble_done;
    logic sync_ok;
    logic data_slot_active;

    assign in_data          = (slot_q < SLOT_W'(DATA_BITS));
    assign is_last          = (slot_q == SLOT_W'(SLOT_LAST));
    assign nibble_done      = in_data && (slot_q[1:0] == 2'b11);
    assign data_slot_active = (state_q != ST_HUNT) && in_data;

`ifdef SERDESPHY_RX_DESCRAMBLE_EN
    // Additive descrambler x^7+x^6+1, restarted at every sync slot end so
    // each frame's payload is descrambled from the same seed.
    logic [6:0] lfsr_q, lfsr_d;
    logic       scr_bit;

    assign scr_bit = lfsr_q[6] ^ lfsr_q[5];
    assign bit_in  = rx_bit ^ (data_slot_active & scr_bit);

    always_comb begin
        lfsr_d = lfsr_q;
        if (rx_bit_en && !resync) begin
            if ((state_q == ST_HUNT && sync_ok) || (state_q != ST_HUNT && is_last)) begin
                lfsr_d = 7'h7F;
            end else if (data_slot_active) begin
                lfsr_d = {lfsr_q[5:0], scr_bit};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= 7'h7F;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    assign bit_in = rx_bit;
`endif

    assign sr_d    = rx_bit_en ? {sr_q[6:0], bit_in} : sr_q;
    assign sync_ok = (sr_d == SYNC_WORD);

    always_comb begin
        state_d       = state_q;
        slot_d        = slot_q;
        hits_d        = hits_q;
        misses_d      = misses_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = 1'b0;
        frame_start_d = 1'b0;
        miss_cnt_d    = miss_cnt_q;

        if (resync) begin
            state_d  = ST_HUNT;
            hits_d   = 4'd0;
            misses_d = 4'd0;
            slot_d   = '0;
        end else if (rx_bit_en) begin
            case (state_q)
                ST_HUNT: begin
                    if (sync_ok) begin
                        slot_d = '0;
                        hits_d = 4'd1;
                        if (LOCK_CNT == 1) begin
                            state_d  = ST_LOCKED;
                            misses_d = 4'd0;
                        end else begin
                            state_d = ST_CHECK;
                        end
                    end
                end
                ST_CHECK: begin
                    slot_d = is_last ? '0 : slot_q + 1'b1;
                    if (is_last) begin
                        if (sync_ok) begin
                            hits_d = hits_q + 4'd1;
                            if (hits_q + 4'd1 == 4'(LOCK_CNT)) begin
                                state_d  = ST_LOCKED;
                                misses_d = 4'd0;
                            end
                        end else begin
                            state_d = ST_HUNT;
                            hits_d  = 4'd0;
                        end
                    end
                end
                ST_LOCKED: begin
                    slot_d = is_last ? '0 : slot_q + 1'b1;
                    if (nibble_done) begin
                        rx_data_d  = sr_d[3:0];
                        rx_valid_d = 1'b1;
                    end
                    if (is_last) begin
                        if (sync_ok) begin
                            misses_d      = 4'd0;
                            frame_start_d = 1'b1;
                        end else begin
                            misses_d = misses_q + 4'd1;
                            if (miss_cnt_q != 8'hFF) begin
                                miss_cnt_d = miss_cnt_q + 8'd1;
                            end
                            if (misses_q + 4'd1 == 4'(LOSS_CNT)) begin
                                state_d = ST_HUNT;
                                hits_d  = 4'd0;
                            end
                        end
                    end
                end
                default: begin
                    state_d = ST_HUNT;
                end
            endcase
        end

        sync_lock_d = (state_d == ST_LOCKED);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_HUNT;
            sr_q          <= 8'd0;
            slot_q        <= '0;
            hits_q        <= 4'd0;
            misses_q      <= 4'd0;
            rx_data_q     <= 4'd0;
            rx_valid_q    <= 1'b0;
            frame_start_q <= 1'b0;
            sync_lock_q   <= 1'b0;
            miss_cnt_q    <= 8'd0;
        end else begin
            state_q       <= state_d;
            sr_q          <= sr_d;
            slot_q        <= slot_d;
            hits_q        <= hits_d;
            misses_q      <= misses_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            frame_start_q <= frame_start_d;
            sync_lock_q   <= sync_lock_d;
            miss_cnt_q    <= miss_cnt_d;
        end
    end

    assign rx_data       = rx_data_q;
    assign rx_valid      = rx_valid_q;
    assign frame_start   = frame_start_q;
    assign sync_lock     = sync_lock_q;
    assign sync_miss_cnt = miss_cnt_q;

endmodule

// File: tb/tb_serdesphy_rx_framer.sv
// Directed bench for serdesphy_rx_framer: frame tables plus hand-written
// reset and resync sequences, with continuous and gapped bit strobes.
module tb_serdesphy_rx_framer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_bit;
    logic       rx_bit_en;
    logic       resync;
    logic [3:0] rx_data;
    logic       rx_valid;
    logic       frame_start;
    logic       sync_lock;
    logic [7:0] sync_miss_cnt;

    always #5 clk = ~clk;

    serdesphy_rx_framer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_bit       (rx_bit),
        .rx_bit_en    (rx_bit_en),
        .resync       (resync),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .frame_start  (frame_start),
        .sync_lock    (sync_lock),
        .sync_miss_cnt(sync_miss_cnt)
    );

    typedef struct {
        logic [7:0] sync;
        int         lock_pre;
        int         lock_post;
        int         fs;
        int         miss;
        int         nibs;
    } frame_vec_t;

    int         checks   = 0;
    int         failures = 0;
    int         gap      = 0;
    int         fs_count = 0;
    logic [3:0] nib_q[$];

    frame_vec_t tab_a[13];
    frame_vec_t tab_b[5];
    frame_vec_t tab_c[4];

    always @(negedge clk) begin
        if (rx_valid) nib_q.push_back(rx_data);
        if (frame_start) fs_count++;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic rs);
        rx_bit_en = 1'b0;
        resync    = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        rx_bit    = b;
        rx_bit_en = 1'b1;
        resync    = rs;
        @(posedge clk);
        #1;
        rx_bit_en = 1'b0;
        resync    = 1'b0;
    endtask

    task automatic send_nibble(input logic [3:0] n);
        for (int i = 3; i >= 0; i--) send_bit(n[i], 1'b0);
    endtask

    task automatic do_reset(input string tag);
        rst_n     = 1'b0;
        rx_bit_en = 1'b1;
        resync    = 1'b0;
        repeat (4) begin
            rx_bit = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        sample();
        check({tag, "_rx_data"},     int'(rx_data), 0);
        check({tag, "_rx_valid"},    int'(rx_valid), 0);
        check({tag, "_frame_start"}, int'(frame_start), 0);
        check({tag, "_sync_lock"},   int'(sync_lock), 0);
        check({tag, "_miss_cnt"},    int'(sync_miss_cnt), 0);
        rx_bit_en = 1'b0;
        rst_n     = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_frame(input frame_vec_t v, input string tag);
        int fs0;
        int base;
        int got;
        logic [7:0] s;
        s = v.sync;
        for (int i = 7; i >= 1; i--) send_bit(s[i], 1'b0);
        sample();
        check({tag, "_lock_pre"}, int'(sync_lock), v.lock_pre);
        fs0 = fs_count;
        send_bit(s[0], 1'b0);
        sample();
        check({tag, "_lock_post"},   int'(sync_lock), v.lock_post);
        check({tag, "_frame_start"}, fs_count - fs0, v.fs);
        check({tag, "_miss_cnt"},    int'(sync_miss_cnt), v.miss);
        base = nib_q.size();
        for (int k = 1; k <= 8; k++) send_nibble(4'(k));
        sample();
        check({tag, "_nib_count"}, nib_q.size() - base, v.nibs);
        for (int k = 0; k < v.nibs; k++) begin
            got = (base + k < nib_q.size()) ? int'(nib_q[base + k]) : -1;
            check($sformatf("%s_nib%0d", tag, k), got, k + 1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        rst_n     = 1'b0;
        rx_bit    = 1'b0;
        rx_bit_en = 1'b0;
        resync    = 1'b0;

        //           sync    pre post fs miss nibs
        tab_a[0]  = '{8'hD2, 0, 0, 0, 0, 0};
        tab_a[1]  = '{8'hD2, 0, 0, 0, 0, 0};
        tab_a[2]  = '{8'hD2, 0, 1, 0, 0, 8};
        tab_a[3]  = '{8'hD2, 1, 1, 1, 0, 8};
        tab_a[4]  = '{8'hD3, 1, 1, 0, 1, 8};
        tab_a[5]  = '{8'hD2, 1, 1, 1, 1, 8};
        tab_a[6]  = '{8'h00, 1, 1, 0, 2, 8};
        tab_a[7]  = '{8'h00, 1, 0, 0, 3, 0};
        tab_a[8]  = '{8'hD2, 0, 0, 0, 3, 0};
        tab_a[9]  = '{8'hD0, 0, 0, 0, 3, 0};
        tab_a[10] = '{8'hD2, 0, 0, 0, 3, 0};
        tab_a[11] = '{8'hD2, 0, 0, 0, 3, 0};
        tab_a[12] = '{8'hD2, 0, 1, 0, 3, 8};

        tab_b[0]  = '{8'hD2, 0, 0, 0, 0, 0};
        tab_b[1]  = '{8'hD2, 0, 0, 0, 0, 0};
        tab_b[2]  = '{8'hD2, 0, 1, 0, 0, 8};
        tab_b[3]  = '{8'hD3, 1, 1, 0, 1, 8};
        tab_b[4]  = '{8'hD2, 1, 1, 1, 1, 8};

        tab_c[0]  = '{8'hD2, 0, 0, 0, 1, 0};
        tab_c[1]  = '{8'hD2, 0, 0, 0, 1, 0};
        tab_c[2]  = '{8'hD2, 0, 1, 0, 1, 8};
        tab_c[3]  = '{8'hD2, 1, 1, 1, 1, 8};

        do_reset("rst0");
        gap = 0;
        for (int i = 0; i < 13; i++) apply_frame(tab_a[i], $sformatf("a%0d", i));

        do_reset("rst1");
        gap = 2;
        for (int i = 0; i < 5; i++) apply_frame(tab_b[i], $sformatf("b%0d", i));

        // Locked, gapped strobes: resync lands on the bit that completes nibble 4.
        for (int i = 7; i >= 0; i--) send_bit(tab_a[0].sync[i], 1'b0);
        sample();
        check("rs_lock_before", int'(sync_lock), 1);
        base = nib_q.size();
        for (int k = 1; k <= 3; k++) send_nibble(4'(k));
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b1);
        sample();
        check("rs_lock_after", int'(sync_lock), 0);
        check("rs_rx_valid",   int'(rx_valid), 0);
        check("rs_nib_count",  nib_q.size() - base, 3);
        check("rs_rx_data_hold", int'(rx_data), 3);
        check("rs_miss_kept",  int'(sync_miss_cnt), 1);
        for (int k = 5; k <= 8; k++) send_nibble(4'(k));
        sample();
        check("rs_nib_count_tail", nib_q.size() - base, 3);
        check("rs_lock_tail", int'(sync_lock), 0);

        for (int i = 0; i < 4; i++) apply_frame(tab_c[i], $sformatf("c%0d", i));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
